// File: rtl/queue_n_to_1_pkg.sv
// Shared helpers for the N-to-1 queue: compile-time width arithmetic.
package queue_n_to_1_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/queue_n_to_1.sv
// Multi-lane push, single-element pull circular queue.
// Up to Lanes elements are written per cycle; Q shows the head combinationally.
module queue_n_to_1
    import queue_n_to_1_pkg::*;
#(
    parameter int unsigned Width        = 8,
    parameter int unsigned Lanes        = 2,
    parameter int unsigned AddressWidth = 3,
    localparam int unsigned Depth       = 1 << AddressWidth,
    localparam int unsigned CW          = clog2(Lanes + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic [CW-1:0]             lanes,
    input  logic [Width*Lanes-1:0]    D,
    input  logic                      pull,
    output logic [Width-1:0]          Q,
    // `void` is a reserved word in SystemVerilog
    output logic                      void_o,
    output logic                      full,
    output logic [AddressWidth:0]     level,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int unsigned LW = AddressWidth + 1;

    logic [Width-1:0]        mem_q [Depth];
    logic [AddressWidth-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [LW-1:0]           level_q, level_d;
    logic                    ovf_q, ovf_d, unf_q, unf_d;
    logic [LW-1:0]           lanes_w, room;
    logic                    push_ok, pull_ok;

    always_comb begin
        lanes_w = LW'(lanes);
        // Space is judged on the pre-edge level; a same-cycle pull frees nothing.
        room    = LW'(Depth) - level_q;
        push_ok = push && (lanes_w != '0) && (lanes_w <= room);
        pull_ok = pull && (level_q != '0);

        wp_d    = push_ok ? wp_q + AddressWidth'(lanes_w) : wp_q;
        rp_d    = pull_ok ? rp_q + AddressWidth'(1) : rp_q;
        level_d = level_q + (push_ok ? lanes_w : '0) - (pull_ok ? LW'(1) : '0);
        ovf_d   = ovf_q | (push && (lanes_w != '0) && !push_ok);
        unf_d   = unf_q | (pull && !pull_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is not reset; lane k lands at wp+k, wrapping modulo Depth.
    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < Lanes; k++) begin
            if (push_ok && (k < 32'(lanes))) begin
                mem_q[wp_q + AddressWidth'(k)] <= D[Width*k +: Width];
            end
        end
    end

    always_comb begin
        Q         = mem_q[rp_q];
        void_o    = (level_q == '0);
        full      = (level_q > LW'(Depth - Lanes));
        level     = level_q;
        overflow  = ovf_q;
        underflow = unf_q;
    end

endmodule

// File: tb/tb_queue_n_to_1.sv
// Scoreboard bench for queue_n_to_1 against a queue-based reference model.
module tb_queue_n_to_1;

    localparam int W     = 8;
    localparam int L     = 2;
    localparam int AW    = 3;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic [1:0]    lanes_s = '0;
    logic [15:0]   d_s = '0;
    logic          pull = 1'b0;
    logic [7:0]    q_s;
    logic          void_s, full_s, ovf_s, unf_s;
    logic [AW:0]   level_s;

    queue_n_to_1 #(.Width(W), .Lanes(L), .AddressWidth(AW)) dut (
        .clk(clk), .rst(rst), .push(push), .lanes(lanes_s), .D(d_s),
        .pull(pull), .Q(q_s), .void_o(void_s), .full(full_s),
        .level(level_s), .overflow(ovf_s), .underflow(unf_s)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    byte unsigned mdl[$];
    byte unsigned sb[$];
    bit   m_ovf = 0, m_unf = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: whenever the DUT offers a head element being pulled, it must match the scoreboard.
    always @(negedge clk) begin
        if (!rst && pull && !void_s) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL Q: got %0h expected nothing (scoreboard empty)", q_s);
            end else begin
                chk("Q", int'(q_s), int'(sb.pop_front()));
            end
        end
    end

    task automatic check_state();
        chk("level", int'(level_s), mdl.size());
        chk("void", int'(void_s), int'(mdl.size() == 0));
        chk("full", int'(full_s), int'(mdl.size() > DEPTH - L));
        chk("overflow", int'(ovf_s), int'(m_ovf));
        chk("underflow", int'(unf_s), int'(m_unf));
    endtask

    // Called just after a posedge; drives one cycle, advances the model, checks after the edge.
    task automatic cyc(input bit p, input int l, input logic [15:0] d, input bit pl);
        int lvl;
        bit acc_push, acc_pull;
        push    = p;
        lanes_s = 2'(l);
        d_s     = d;
        pull    = pl;
        lvl      = mdl.size();
        acc_push = p && (l > 0) && (l <= DEPTH - lvl);
        acc_pull = pl && (lvl > 0);
        if (p && l > 0 && !acc_push) m_ovf = 1;
        if (pl && lvl == 0) m_unf = 1;
        if (acc_pull) void'(mdl.pop_front());
        if (acc_push) begin
            for (int k = 0; k < l; k++) begin
                mdl.push_back(d[8*k +: 8]);
                sb.push_back(d[8*k +: 8]);
            end
        end
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        push = 0; pull = 0; lanes_s = '0;
        rst = 1'b1;
        #2;
        mdl.delete(); sb.delete(); m_ovf = 0; m_unf = 0;
        check_state();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Two-lane push then two pulls, oldest lane first
        cyc(1, 2, 16'hB2A1, 0);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 1);

        // Fill to 7, overflow on a further two-lane push, drain in order
        cyc(1, 1, 16'h0001, 0);
        cyc(1, 2, 16'h0302, 0);
        cyc(1, 2, 16'h0504, 0);
        cyc(1, 2, 16'h0706, 0);
        cyc(1, 2, 16'h0908, 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 16'h0, 1);

        // Wrap-around past the last entry
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1, 2, 16'(16'h2120 + i * 16'h0202), 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 16'h0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 2, 16'(16'h3130 + i * 16'h0202), 0);
        for (int i = 0; i < 7; i++) cyc(0, 0, 16'h0, 1);

        // Simultaneous pull and push at level 1
        do_reset();
        cyc(1, 1, 16'h0010, 0);
        cyc(1, 2, 16'h1211, 1);
        cyc(0, 0, 16'h0, 1);
        cyc(0, 0, 16'h0, 1);

        // Underflow, zero-lane no-op, then reset mid-stream at level 5
        cyc(0, 0, 16'h0, 1);
        cyc(1, 0, 16'hEEEE, 0);
        cyc(1, 2, 16'h4241, 0);
        cyc(1, 2, 16'h4443, 0);
        cyc(1, 1, 16'h0045, 0);
        do_reset();
        cyc(1, 1, 16'h0055, 0);
        cyc(0, 0, 16'h0, 1);

        // Randomized traffic with phases biased toward filling and draining
        for (int i = 0; i < 3000; i++) begin
            int bias;
            bias = ((i / 100) % 2 == 0) ? 70 : 30;
            cyc($urandom_range(0, 99) < bias, int'($urandom_range(0, L)),
                16'($urandom), $urandom_range(0, 99) >= bias);
        end

        push = 0; pull = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
